spi_master_slave: RTL and testbench

- Self-contained SPI link: one SPI master engine and one SPI slave engine exchanging 8-bit words full-duplex over internal SCLK/MOSI/MISO nets.
- Both engines run in the single system clock domain.
- The host loads the master transmit byte and the slave preloads its reply byte; a start pulse swaps them. Both received bytes are then readable.
- Sits between the system bus glue and the SPI pins. SCLK/MOSI/MISO are also exported for observation and pin muxing.

---
 rtl/spi_master_slave.sv | 153 +++++++++++++++
 tb/tb_spi_master_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// SPI master and slave engines exchanging one 8-bit word full-duplex over internal sclk/mosi/miso.
// Define SPI_LSB_FIRST_EN to shift LSB first on both engines (MSB first otherwise).
module spi_master_slave #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load,
    input  logic [7:0] master_data_in,
    output logic [7:0] master_data_out,
    output logic       busy,
    output logic       done,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       cs_n,
    input  logic       slave_en_write,
    input  logic [7:0] slave_write,
    input  logic       slave_en_read,
    output logic [7:0] slave_read,
    output logic       sclk,
    output logic       mosi,
    output logic       miso
);

`ifdef SPI_LSB_FIRST_EN
    localparam int unsigned OB = 0;
    function automatic logic [7:0] shift_in(input logic [7:0] x, input logic b);
        return (x >> 1) | {b, 7'b0};
    endfunction
`else
    localparam int unsigned OB = 7;
    function automatic logic [7:0] shift_in(input logic [7:0] x, input logic b);
        return (x << 1) | {7'b0, b};
    endfunction
`endif

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] div_cnt;
    logic [3:0]    edge_cnt, s_bits;
    logic          cpol_r, cpha_r, sclk_r, mosi_r;
    logic [7:0]    master_tx, m_sh, m_rx, slave_tx, s_sh, s_rx;
    logic [7:0]    m_tx_eff, s_tx_eff, m_sh_nxt, s_sh_nxt, m_rx_nxt, s_rx_nxt;
    logic          tick, last_edge, sclk_nxt;
    logic          m_sample, m_shift, s_edge, s_lead, s_sample, s_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: state_nxt = start ? S_XFER : S_IDLE;
            S_XFER:         if (last_edge) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_XFER);
        done = (state == S_DONE);
    end

    // Edge events are decoded from the next sclk value so both engines act on the same clk edge
    always_comb begin
        tick      = busy && (div_cnt == DIV_LAST);
        last_edge = tick && (edge_cnt == 4'd15);
        sclk_nxt  = !busy ? cpol : (tick ? ~sclk_r : sclk_r);
        m_sample  = tick && (edge_cnt[0] == cpha_r);
        m_shift   = tick && (edge_cnt[0] != cpha_r) &&
                    (cpha_r ? (edge_cnt != 4'd0) : (edge_cnt != 4'd15));
        s_edge    = tick && !cs_n;
        s_lead    = (sclk_nxt != cpol_r);
        s_sample  = s_edge && (s_lead != cpha_r);
        s_shift   = s_edge && (s_lead == cpha_r) &&
                    (cpha_r ? (s_bits != 4'd0) : (s_bits != 4'd8));
        m_tx_eff  = load ? master_data_in : master_tx;
        s_tx_eff  = slave_en_write ? slave_write : slave_tx;
        miso      = cs_n ? 1'b1 : (busy ? s_sh[OB] : slave_tx[OB]);
        m_sh_nxt  = shift_in(m_sh, 1'b0);
        s_sh_nxt  = shift_in(s_sh, 1'b0);
        m_rx_nxt  = shift_in(m_rx, miso);
        s_rx_nxt  = shift_in(s_rx, mosi_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt         <= '0;
            edge_cnt        <= '0;
            s_bits          <= '0;
            cpol_r          <= 1'b0;
            cpha_r          <= 1'b0;
            sclk_r          <= 1'b0;
            mosi_r          <= 1'b0;
            master_tx       <= '0;
            m_sh            <= '0;
            m_rx            <= '0;
            slave_tx        <= '0;
            s_sh            <= '0;
            s_rx            <= '0;
            master_data_out <= '0;
            slave_read      <= '0;
        end else begin
            sclk_r <= sclk_nxt;
            if (slave_en_read) slave_read <= s_rx;
            if (!busy) begin
                if (load)           master_tx <= master_data_in;
                if (slave_en_write) slave_tx  <= slave_write;
                mosi_r <= m_tx_eff[OB];
                if (start) begin
                    m_sh     <= m_tx_eff;
                    s_sh     <= s_tx_eff;
                    cpol_r   <= cpol;
                    cpha_r   <= cpha;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    s_bits   <= '0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    edge_cnt <= edge_cnt + 1'b1;
                    if (m_sample) m_rx <= m_rx_nxt;
                    if (m_shift) begin
                        m_sh   <= m_sh_nxt;
                        mosi_r <= m_sh_nxt[OB];
                    end
                    // Final edge may also be the last master sample (cpha=1)
                    if (last_edge) begin
                        master_data_out <= m_sample ? m_rx_nxt : m_rx;
                        mosi_r          <= master_tx[OB];
                    end
                    if (s_sample) begin
                        s_rx   <= s_rx_nxt;
                        s_bits <= s_bits + 1'b1;
                    end
                    if (s_shift) s_sh <= s_sh_nxt;
                end
            end
        end
    end

    assign sclk = sclk_r;
    assign mosi = mosi_r;

endmodule

// File: tb/tb_spi_master_slave.sv
// Self-checking bench for spi_master_slave: directed vector table, reset abort sequence and random transfers.
module tb_spi_master_slave;

    localparam int unsigned DIV = 1;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       clk, reset, start, load, cpol, cpha, cs_n;
    logic       slave_en_write, slave_en_read;
    logic [7:0] master_data_in, master_data_out, slave_write, slave_read;
    logic       busy, done, sclk, mosi, miso;

    spi_master_slave #(.CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .load(load),
        .master_data_in(master_data_in), .master_data_out(master_data_out),
        .busy(busy), .done(done), .cpol(cpol), .cpha(cpha), .cs_n(cs_n),
        .slave_en_write(slave_en_write), .slave_write(slave_write),
        .slave_en_read(slave_en_read), .slave_read(slave_read),
        .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cpol, cpha, csn;
        logic [7:0] m, s;
        bit         same, poke;
        logic [7:0] exp_mdo, exp_sread;
    } vec_t;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] ref_sread;
    vec_t       tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic idle_bit(input logic [7:0] x);
        return LSB ? x[0] : x[7];
    endfunction

    function automatic vec_t mk(input logic pol, input logic pha, input logic csn,
                                input logic [7:0] m, input logic [7:0] s,
                                input bit same, input bit poke,
                                input logic [7:0] emdo, input logic [7:0] esr);
        vec_t v;
        v.cpol = pol; v.cpha = pha; v.csn = csn; v.m = m; v.s = s;
        v.same = same; v.poke = poke; v.exp_mdo = emdo; v.exp_sread = esr;
        return v;
    endfunction

    task automatic run_xfer(input vec_t v);
        int         busy_cnt, done_cnt, done_k, nsamp, pos;
        logic       prev_sclk, prev_mosi, prev_miso, lead;
        logic [7:0] mo_b, mi_b;
        busy_cnt = 0; done_cnt = 0; done_k = 0; nsamp = 0;
        mo_b = '0; mi_b = '0;
        @(negedge clk);
        cpol = v.cpol; cpha = v.cpha; cs_n = v.csn;
        if (!v.same) begin
            load = 1'b1; master_data_in = v.m;
            slave_en_write = 1'b1; slave_write = v.s;
            @(negedge clk);
            load = 1'b0; slave_en_write = 1'b0;
        end
        @(negedge clk);
        chk("sclk_idle_pre", 32'(sclk), 32'(v.cpol));
        if (!v.same) chk("mosi_idle_pre", 32'(mosi), 32'(idle_bit(v.m)));
        start = 1'b1;
        if (v.same) begin
            load = 1'b1; master_data_in = v.m;
            slave_en_write = 1'b1; slave_write = v.s;
        end
        prev_sclk = sclk; prev_mosi = mosi; prev_miso = miso;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; load = 1'b0; slave_en_write = 1'b0;
            end
            if (v.poke && k == 5) begin
                start = 1'b1; load = 1'b1; master_data_in = ~v.m;
                slave_en_write = 1'b1; slave_write = ~v.s;
            end
            if (v.poke && k == 6) begin
                start = 1'b0; load = 1'b0; slave_en_write = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_k = k;
                    chk("mdo_at_done", 32'(master_data_out), 32'(v.exp_mdo));
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
            // The bit captured on a sampling edge is the one present just before it
            if (sclk !== prev_sclk) begin
                lead = (sclk !== v.cpol);
                if (lead != v.cpha) begin
                    if (nsamp < 8) begin
                        pos = LSB ? nsamp : 7 - nsamp;
                        mo_b[pos] = prev_mosi;
                        mi_b[pos] = prev_miso;
                    end
                    nsamp++;
                end
            end
            prev_sclk = sclk; prev_mosi = mosi; prev_miso = miso;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd16);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("done_cycle", 32'(done_k), 32'd17);
        chk("sample_edges", 32'(nsamp), 32'd8);
        chk("mosi_stream", 32'(mo_b), 32'(v.m));
        chk("miso_stream", 32'(mi_b), 32'(v.exp_mdo));
        chk("sclk_idle_post", 32'(sclk), 32'(v.cpol));
        chk("mdo_hold", 32'(master_data_out), 32'(v.exp_mdo));
        chk("mosi_idle_post", 32'(mosi), 32'(idle_bit(v.m)));
        slave_en_read = 1'b1;
        @(negedge clk);
        slave_en_read = 1'b0;
        chk("slave_read", 32'(slave_read), 32'(v.exp_sread));
        ref_sread = v.exp_sread;
    endtask

    initial begin
        int   dcnt;
        vec_t v;
        reset = 1'b1; start = 1'b0; load = 1'b0; cpol = 1'b0; cpha = 1'b0; cs_n = 1'b1;
        slave_en_write = 1'b0; slave_en_read = 1'b0;
        master_data_in = '0; slave_write = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mdo", 32'(master_data_out), 32'd0);
        chk("rst_sread", 32'(slave_read), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_miso_csn1", 32'(miso), 32'd1);
        reset = 1'b0;
        cpol = 1'b1;
        @(negedge clk);
        chk("sclk_follows_cpol", 32'(sclk), 32'd1);
        cpol = 1'b0;
        ref_sread = '0;

        tbl[0] = mk(0, 0, 0, 8'hA5, 8'hFF, 0, 0, 8'hFF, 8'hA5);
        tbl[1] = mk(0, 1, 0, 8'h3C, 8'hC3, 0, 0, 8'hC3, 8'h3C);
        tbl[2] = mk(1, 0, 0, 8'h3C, 8'hC3, 1, 0, 8'hC3, 8'h3C);
        tbl[3] = mk(1, 1, 0, 8'h3C, 8'hC3, 0, 0, 8'hC3, 8'h3C);
        tbl[4] = mk(0, 0, 1, 8'h5A, 8'h12, 0, 0, 8'hFF, 8'h3C);
        tbl[5] = mk(0, 1, 0, 8'hE7, 8'h18, 1, 1, 8'h18, 8'hE7);
        tbl[6] = mk(0, 0, 0, 8'h01, 8'h80, 0, 0, 8'h80, 8'h01);
        tbl[7] = mk(1, 1, 0, 8'h00, 8'hFF, 1, 1, 8'hFF, 8'h00);
        for (int i = 0; i < 8; i++) run_xfer(tbl[i]);

        // Reset five cycles into a transfer aborts it with no done pulse
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; cs_n = 1'b0;
        load = 1'b1; master_data_in = 8'h96; slave_en_write = 1'b1; slave_write = 8'h69; start = 1'b1;
        @(negedge clk);
        load = 1'b0; slave_en_write = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mdo", 32'(master_data_out), 32'd0);
        chk("abort_sread", 32'(slave_read), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_miso", 32'(miso), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done_after_abort", 32'(dcnt), 32'd0);
        ref_sread = '0;
        run_xfer(mk(0, 0, 0, 8'h96, 8'h69, 1, 0, 8'h69, 8'h96));

        for (int i = 0; i < 25; i++) begin
            v.cpol = 1'($urandom_range(0, 1));
            v.cpha = 1'($urandom_range(0, 1));
            v.csn  = ($urandom_range(0, 3) == 0);
            v.m    = 8'($urandom);
            v.s    = 8'($urandom);
            v.same = 1'($urandom_range(0, 1));
            v.poke = 1'($urandom_range(0, 1));
            v.exp_mdo   = v.csn ? 8'hFF : v.s;
            v.exp_sread = v.csn ? ref_sread : v.m;
            run_xfer(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
